// File: rtl/ctu_tsr_pkg.sv
// rtl/ctu_tsr_pkg.sv - shared types, defaults and counter widths for the temperature sensor controller
package ctu_tsr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    CONV  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } tsr_state_e;

  localparam int TSR_DATA_W   = 8;
  localparam int TSR_CONV_CYC = 64;

  // $clog2 clamped to at least one bit so a count of 1 still yields a legal vector
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TSR_CONV_CNT_W = cnt_w(TSR_CONV_CYC);
  localparam int TSR_BIT_CNT_W  = cnt_w(TSR_DATA_W);

endpackage

// File: rtl/ctu_tsr_ctl_if.sv
// rtl/ctu_tsr_ctl_if.sv - CSR and pad-side signal bundle for the temperature sensor controller
interface ctu_tsr_ctl_if
  import ctu_tsr_pkg::*;
#(
  parameter int DATA_W = TSR_DATA_W
);

  logic              csr_tsr_en;
  logic [DATA_W-1:0] csr_tsr_thr;
  logic              csr_alarm_clr;
  logic              tsr_sdata;
  logic              tsr_start;
  logic              tsr_sclk;
  logic              tsr_busy;
  logic [DATA_W-1:0] tsr_temp;
  logic              tsr_temp_vld;
  logic              tsr_alarm;

  // CSR block and pad cluster side
  modport master (
    output csr_tsr_en, csr_tsr_thr, csr_alarm_clr, tsr_sdata,
    input  tsr_start, tsr_sclk, tsr_busy, tsr_temp, tsr_temp_vld, tsr_alarm
  );

  // controller side
  modport slave (
    input  csr_tsr_en, csr_tsr_thr, csr_alarm_clr, tsr_sdata,
    output tsr_start, tsr_sclk, tsr_busy, tsr_temp, tsr_temp_vld, tsr_alarm
  );

endinterface

// File: rtl/ctu_tsr_shift.sv
// rtl/ctu_tsr_shift.sv - serial clock phase, bit counter and MSB-first receive shift register
module ctu_tsr_shift
  import ctu_tsr_pkg::*;
#(
  parameter int DATA_W = TSR_DATA_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              shift_go,
  input  logic              sdata,
  output logic              sclk,
  output logic              last_bit,
  output logic [DATA_W-1:0] data
);

  localparam int BIT_W = cnt_w(DATA_W);

  logic             phase;
  logic [BIT_W-1:0] bit_cnt;

  // phase is itself the pad clock: low in the first half of a bit period, high in the second
  assign sclk     = phase;
  assign last_bit = shift_go & phase & (bit_cnt == BIT_W'(DATA_W - 1));

  // toggle phase while shifting; capture one bit at the end of every high phase
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      phase   <= 1'b0;
      bit_cnt <= '0;
      data    <= '0;
    end else if (shift_go) begin
      phase <= ~phase;
      if (phase) begin
        data    <= (data << 1) | DATA_W'(sdata);
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end else begin
      phase   <= 1'b0;
      bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/ctu_tsr_ctl.sv
// rtl/ctu_tsr_ctl.sv - temperature sensor conversion controller (optional averaging: TSR_AVG_EN)
module ctu_tsr_ctl
  import ctu_tsr_pkg::*;
#(
  parameter int DATA_W   = TSR_DATA_W,
  parameter int CONV_CYC = TSR_CONV_CYC
) (
  input logic          clk,
  input logic          rst_l,
  ctu_tsr_ctl_if.slave bus
);

  localparam int CONV_W = cnt_w(CONV_CYC);

  tsr_state_e        state;
  logic [CONV_W-1:0] conv_cnt;
  logic              shift_go;
  logic              last_bit;
  logic              sclk;
  logic [DATA_W-1:0] shift_data;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] reported;

  assign shift_go     = (state == SHIFT);
  assign bus.tsr_sclk = sclk;

  // the final bit is folded in here so the result is ready on the same edge that enters DONE
  assign raw = (shift_data << 1) | DATA_W'(bus.tsr_sdata);

  ctu_tsr_shift #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk     (clk),
    .rst_l   (rst_l),
    .shift_go(shift_go),
    .sdata   (bus.tsr_sdata),
    .sclk    (sclk),
    .last_bit(last_bit),
    .data    (shift_data)
  );

`ifdef TSR_AVG_EN
  logic              seeded;
  logic [DATA_W:0]   avg_sum;

  assign avg_sum  = {1'b0, bus.tsr_temp} + {1'b0, raw} + (DATA_W + 1)'(1);
  assign reported = seeded ? avg_sum[DATA_W:1] : raw;

  // first result after reset has nothing to average against, so it loads unfiltered
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      seeded <= 1'b0;
    end else if (shift_go && last_bit) begin
      seeded <= 1'b1;
    end
  end
`else
  assign reported = raw;
`endif

  // conversion sequencer; all pad and CSR outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state            <= IDLE;
      conv_cnt         <= '0;
      bus.tsr_start    <= 1'b0;
      bus.tsr_busy     <= 1'b0;
      bus.tsr_temp     <= '0;
      bus.tsr_temp_vld <= 1'b0;
    end else begin
      bus.tsr_start    <= 1'b0;
      bus.tsr_temp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.csr_tsr_en) begin
            state         <= START;
            bus.tsr_start <= 1'b1;
            bus.tsr_busy  <= 1'b1;
          end
        end
        START: begin
          state    <= CONV;
          conv_cnt <= '0;
        end
        CONV: begin
          if (conv_cnt == CONV_W'(CONV_CYC - 1)) begin
            state    <= SHIFT;
            conv_cnt <= '0;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            state            <= DONE;
            bus.tsr_temp     <= reported;
            bus.tsr_temp_vld <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.tsr_busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.tsr_busy <= 1'b0;
        end
      endcase
    end
  end

  // sticky alarm: compare happens at the end of DONE so a clear in that cycle loses to a set
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bus.tsr_alarm <= 1'b0;
    end else if ((state == DONE) && (bus.tsr_temp >= bus.csr_tsr_thr)) begin
      bus.tsr_alarm <= 1'b1;
    end else if (bus.csr_alarm_clr) begin
      bus.tsr_alarm <= 1'b0;
    end
  end

endmodule
